// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath strobes and mux selects, with req/ready handshakes to IM and DM.
module mc_controller #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       IMReady,
    input  logic       DMReady,
    output logic       IMReq,
    output logic       IRWE,
    output logic       PCWE,
    output logic [1:0] PCSel,
    output logic       RegWE,
    output logic [1:0] RegA3Sel,
    output logic [1:0] DatatoReg,
    output logic       ALUBSel,
    output logic [2:0] ALUCtrl,
    output logic [1:0] EXTCtrl,
    output logic       DMReq,
    output logic       DMWE,
    output logic       InstrDone,
    output logic       Illegal,
    output logic       Timeout,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        MADDR  = 4'd4,
        MRD    = 4'd5,
        MWR    = 4'd6,
        WB     = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_NOP, C_ADDU, C_SUBU, C_ORI, C_LUI,
        C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR
    } iclass_t;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_t  state_q, state_d;
    iclass_t class_q, class_d;
    iclass_t decClass;
    logic [7:0] waitCnt_q, waitCnt_d;
    logic memWait;

    always_comb begin
        decClass = C_NONE;
        case (Opcode)
            6'b000000: begin
                case (Funct)
                    6'b100001: decClass = C_ADDU;
                    6'b100011: decClass = C_SUBU;
                    6'b001000: decClass = C_JR;
                    6'b000000: decClass = C_NOP;
                    default:   decClass = C_NONE;
                endcase
            end
            6'b001101: decClass = C_ORI;
            6'b001111: decClass = C_LUI;
            6'b100011: decClass = C_LW;
            6'b101011: decClass = C_SW;
            6'b000100: decClass = C_BEQ;
            6'b000010: decClass = C_J;
            6'b000011: decClass = C_JAL;
            default:   decClass = C_NONE;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        waitCnt_d = waitCnt_q;
        memWait   = 1'b0;
        IMReq     = 1'b0;
        IRWE      = 1'b0;
        PCWE      = 1'b0;
        PCSel     = 2'd0;
        RegWE     = 1'b0;
        RegA3Sel  = 2'd0;
        DatatoReg = 2'd0;
        ALUBSel   = 1'b0;
        ALUCtrl   = ALU_ADD;
        EXTCtrl   = 2'd0;
        DMReq     = 1'b0;
        DMWE      = 1'b0;
        InstrDone = 1'b0;
        Illegal   = 1'b0;
        Timeout   = 1'b0;

        case (state_q)
            FETCH: begin
                IMReq = 1'b1;
                if (IMReady) begin
                    IRWE    = 1'b1;
                    PCWE    = 1'b1;
                    state_d = DECODE;
                end else if (waitCnt_q == WAIT_LAST) begin
                    Timeout = 1'b1;
                end else begin
                    memWait = 1'b1;
                end
            end
            DECODE: begin
                class_d = decClass;
                case (decClass)
                    C_ADDU, C_SUBU:    state_d = EXEC_R;
                    C_ORI, C_LUI:      state_d = EXEC_I;
                    C_LW, C_SW:        state_d = MADDR;
                    C_BEQ:             state_d = BRANCH;
                    C_J, C_JAL, C_JR:  state_d = JUMP;
                    C_NOP: begin
                        InstrDone = 1'b1;
                        state_d   = FETCH;
                    end
                    default: begin
                        Illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            EXEC_R: begin
                ALUCtrl = (class_q == C_SUBU) ? ALU_SUB : ALU_ADD;
                state_d = WB;
            end
            EXEC_I: begin
                ALUBSel = 1'b1;
                ALUCtrl = ALU_OR;
                EXTCtrl = (class_q == C_LUI) ? 2'd2 : 2'd0;
                state_d = WB;
            end
            MADDR: begin
                ALUBSel = 1'b1;
                EXTCtrl = 2'd1;
                state_d = (class_q == C_SW) ? MWR : MRD;
            end
            MRD: begin
                DMReq = 1'b1;
                if (DMReady) begin
                    state_d = WB;
                end else if (waitCnt_q == WAIT_LAST) begin
                    Timeout = 1'b1;
                    state_d = FETCH;
                end else begin
                    memWait = 1'b1;
                end
            end
            MWR: begin
                DMReq = 1'b1;
                if (DMReady) begin
                    DMWE      = 1'b1;
                    InstrDone = 1'b1;
                    state_d   = FETCH;
                end else if (waitCnt_q == WAIT_LAST) begin
                    Timeout = 1'b1;
                    state_d = FETCH;
                end else begin
                    DMWE    = 1'b1;
                    memWait = 1'b1;
                end
            end
            WB: begin
                RegWE     = 1'b1;
                InstrDone = 1'b1;
                state_d   = FETCH;
                case (class_q)
                    C_ADDU, C_SUBU: RegA3Sel = 2'd1;
                    C_LUI: begin
                        DatatoReg = 2'd3;
                        EXTCtrl   = 2'd2;
                    end
                    C_LW:    DatatoReg = 2'd1;
                    default: DatatoReg = 2'd0;
                endcase
            end
            BRANCH: begin
                ALUCtrl   = ALU_SUB;
                PCSel     = 2'd1;
                PCWE      = Zero;
                InstrDone = 1'b1;
                state_d   = FETCH;
            end
            JUMP: begin
                PCWE      = 1'b1;
                InstrDone = 1'b1;
                state_d   = FETCH;
                PCSel     = (class_q == C_JR) ? 2'd3 : 2'd2;
                if (class_q == C_JAL) begin
                    RegWE     = 1'b1;
                    RegA3Sel  = 2'd2;
                    DatatoReg = 2'd2;
                end
            end
            default: state_d = FETCH;
        endcase

        // A timeout restarts the count even when FETCH retries in place.
        if (state_d != state_q || Timeout) begin
            waitCnt_d = 8'd0;
        end else if (memWait) begin
            waitCnt_d = waitCnt_q + 8'd1;
        end

        if (reset) begin
            IMReq     = 1'b0;
            IRWE      = 1'b0;
            PCWE      = 1'b0;
            PCSel     = 2'd0;
            RegWE     = 1'b0;
            RegA3Sel  = 2'd0;
            DatatoReg = 2'd0;
            ALUBSel   = 1'b0;
            ALUCtrl   = ALU_ADD;
            EXTCtrl   = 2'd0;
            DMReq     = 1'b0;
            DMWE      = 1'b0;
            InstrDone = 1'b0;
            Illegal   = 1'b0;
            Timeout   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            class_q   <= C_NONE;
            waitCnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks hand-computed state/strobe sequences
// for each instruction class, timeout and mid-instruction reset.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       IMReady;
    logic       DMReady;
    logic       IMReq, IRWE, PCWE, RegWE, ALUBSel, DMReq, DMWE;
    logic       InstrDone, Illegal, Timeout;
    logic [1:0] PCSel, RegA3Sel, DatatoReg, EXTCtrl;
    logic [2:0] ALUCtrl;
    logic [3:0] State;

    int vectors = 0;
    int miscompares = 0;

    mc_controller #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .IMReady(IMReady), .DMReady(DMReady), .IMReq(IMReq), .IRWE(IRWE),
        .PCWE(PCWE), .PCSel(PCSel), .RegWE(RegWE), .RegA3Sel(RegA3Sel),
        .DatatoReg(DatatoReg), .ALUBSel(ALUBSel), .ALUCtrl(ALUCtrl),
        .EXTCtrl(EXTCtrl), .DMReq(DMReq), .DMWE(DMWE), .InstrDone(InstrDone),
        .Illegal(Illegal), .Timeout(Timeout), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic imr, input logic dmr);
        Opcode  = op;
        Funct   = fn;
        Zero    = z;
        IMReady = imr;
        DMReady = dmr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(6'b001101, 6'd0, 1'b0, 1'b1, 1'b1);
        step();
        step();
        checkOutput("rst_state", 8'(State), 8'd0);
        checkOutput("rst_imreq", 8'(IMReq), 8'd0);
        checkOutput("rst_irwe", 8'(IRWE), 8'd0);
        checkOutput("rst_pcwe", 8'(PCWE), 8'd0);
        reset = 1'b0;

        // ori with the opcode changed after DECODE to exercise class latching
        applyStimulus(6'b001101, 6'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("ori_c1_state", 8'(State), 8'd0);
        checkOutput("ori_c1_irwe", 8'(IRWE), 8'd1);
        checkOutput("ori_c1_done", 8'(InstrDone), 8'd0);
        step();
        checkOutput("ori_c2_state", 8'(State), 8'd1);
        checkOutput("ori_c2_done", 8'(InstrDone), 8'd0);
        step();
        applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("ori_c3_state", 8'(State), 8'd3);
        checkOutput("ori_c3_alub", 8'(ALUBSel), 8'd1);
        checkOutput("ori_c3_aluctrl", 8'(ALUCtrl), 8'd2);
        checkOutput("ori_c3_done", 8'(InstrDone), 8'd0);
        step();
        checkOutput("ori_c4_state", 8'(State), 8'd7);
        checkOutput("ori_c4_regwe", 8'(RegWE), 8'd1);
        checkOutput("ori_c4_ext", 8'(EXTCtrl), 8'd0);
        checkOutput("ori_c4_a3", 8'(RegA3Sel), 8'd0);
        checkOutput("ori_c4_done", 8'(InstrDone), 8'd1);
        step();
        checkOutput("ori_c5_state", 8'(State), 8'd0);
        checkOutput("ori_c5_done", 8'(InstrDone), 8'd0);

        // lw with three stall cycles in MRD
        applyStimulus(6'b100011, 6'd0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("lw_decode", 8'(State), 8'd1);
        step();
        checkOutput("lw_maddr", 8'(State), 8'd4);
        checkOutput("lw_maddr_ext", 8'(EXTCtrl), 8'd1);
        checkOutput("lw_maddr_alub", 8'(ALUBSel), 8'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) applyStimulus(6'b100011, 6'd0, 1'b0, 1'b1, 1'b1);
            checkOutput($sformatf("lw_mrd%0d_state", i), 8'(State), 8'd5);
            checkOutput($sformatf("lw_mrd%0d_dmreq", i), 8'(DMReq), 8'd1);
            checkOutput($sformatf("lw_mrd%0d_dmwe", i), 8'(DMWE), 8'd0);
            checkOutput($sformatf("lw_mrd%0d_tmo", i), 8'(Timeout), 8'd0);
            step();
        end
        applyStimulus(6'b100011, 6'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("lw_wb_state", 8'(State), 8'd7);
        checkOutput("lw_wb_d2r", 8'(DatatoReg), 8'd1);
        checkOutput("lw_wb_dmwe", 8'(DMWE), 8'd0);
        step();
        checkOutput("lw_end_state", 8'(State), 8'd0);

        // beq taken then not taken
        applyStimulus(6'b000100, 6'd0, 1'b1, 1'b1, 1'b0);
        step();
        step();
        checkOutput("beq1_state", 8'(State), 8'd8);
        checkOutput("beq1_pcwe", 8'(PCWE), 8'd1);
        checkOutput("beq1_pcsel", 8'(PCSel), 8'd1);
        checkOutput("beq1_alu", 8'(ALUCtrl), 8'd1);
        checkOutput("beq1_done", 8'(InstrDone), 8'd1);
        step();
        applyStimulus(6'b000100, 6'd0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        checkOutput("beq0_pcwe", 8'(PCWE), 8'd0);
        checkOutput("beq0_done", 8'(InstrDone), 8'd1);
        step();

        // jal then jr
        applyStimulus(6'b000011, 6'd0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        checkOutput("jal_state", 8'(State), 8'd9);
        checkOutput("jal_pcsel", 8'(PCSel), 8'd2);
        checkOutput("jal_regwe", 8'(RegWE), 8'd1);
        checkOutput("jal_a3", 8'(RegA3Sel), 8'd2);
        checkOutput("jal_d2r", 8'(DatatoReg), 8'd2);
        step();
        applyStimulus(6'b000000, 6'b001000, 1'b0, 1'b1, 1'b0);
        step();
        step();
        checkOutput("jr_pcsel", 8'(PCSel), 8'd3);
        checkOutput("jr_regwe", 8'(RegWE), 8'd0);
        checkOutput("jr_pcwe", 8'(PCWE), 8'd1);
        step();

        // addu: register-destination writeback
        applyStimulus(6'b000000, 6'b100001, 1'b0, 1'b1, 1'b0);
        step();
        step();
        checkOutput("addu_state", 8'(State), 8'd2);
        checkOutput("addu_alu", 8'(ALUCtrl), 8'd0);
        step();
        checkOutput("addu_wb_a3", 8'(RegA3Sel), 8'd1);
        step();

        // illegal opcode
        applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("ill_pulse", 8'(Illegal), 8'd1);
        checkOutput("ill_regwe", 8'(RegWE), 8'd0);
        checkOutput("ill_dmwe", 8'(DMWE), 8'd0);
        checkOutput("ill_pcwe", 8'(PCWE), 8'd0);
        step();
        checkOutput("ill_next_state", 8'(State), 8'd0);
        checkOutput("ill_clear", 8'(Illegal), 8'd0);

        // fetch timeout with WAIT_LIMIT = 4
        applyStimulus(6'b101011, 6'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("tmo_wait%0d", i), 8'(Timeout), 8'd0);
            step();
        end
        checkOutput("tmo_pulse", 8'(Timeout), 8'd1);
        checkOutput("tmo_irwe", 8'(IRWE), 8'd0);
        step();
        checkOutput("tmo_state", 8'(State), 8'd0);
        checkOutput("tmo_clear", 8'(Timeout), 8'd0);
        checkOutput("tmo_retry_req", 8'(IMReq), 8'd1);

        // sw, then reset while in MWR
        applyStimulus(6'b101011, 6'd0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        step();
        checkOutput("sw_mwr_state", 8'(State), 8'd6);
        checkOutput("sw_mwr_dmwe", 8'(DMWE), 8'd1);
        step();
        reset = 1'b1;
        #1;
        checkOutput("rstmwr_dmwe", 8'(DMWE), 8'd0);
        checkOutput("rstmwr_dmreq", 8'(DMReq), 8'd0);
        step();
        checkOutput("rstmwr_state", 8'(State), 8'd0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control FSM for the MIPS datapath. It replaces single-cycle combinational decode with a state sequence of Fetch, Decode, Execute, Memory and Writeback.
- Drives the PC, IR, GPR, ALU, EXT and DM control strobes and mux selects.
- Handshakes with instruction memory and data memory through req/ready pairs, so memory latency can vary.
- Sits between IR[31:26]/IR[5:0] and the datapath muxes.

Parameters:
- WAIT_LIMIT, default 255: maximum cycles spent waiting for IMReady/DMReady before the access is aborted. Legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- Opcode  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU equality flag.
- IMReady  in  1  instruction word valid this cycle.
- DMReady  in  1  DM access complete this cycle.
- IMReq  out  1  instruction fetch request.
- IRWE  out  1  IR load.
- PCWE  out  1  PC load.
- PCSel  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = {PC[31:28], imm26, 00}, 3 = GPR[rs].
- RegWE  out  1  GPR write enable.
- RegA3Sel  out  2  write register: 0 = rt, 1 = rd, 2 = $31.
- DatatoReg  out  2  write data: 0 = ALU register, 1 = DM data, 2 = PC+4, 3 = EXT output.
- ALUBSel  out  1  ALU B input: 0 = GPR[rt], 1 = EXT output.
- ALUCtrl  out  3  ALU operation: 0 = ADD, 1 = SUB, 2 = OR.
- EXTCtrl  out  2  extender mode: 0 = zero-extend, 1 = sign-extend, 2 = load to upper half.
- DMReq  out  1  DM access request.
- DMWE  out  1  DM write.
- InstrDone  out  1  one-cycle pulse when an instruction retires.
- Illegal  out  1  one-cycle pulse on an unsupported encoding.
- Timeout  out  1  one-cycle pulse on memory wait overrun.
- State  out  4  current state, for verification.

Behaviour:
- State encoding:
  - FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_I = 3.
  - MADDR = 4, MRD = 5, MWR = 6, WB = 7.
  - BRANCH = 8, JUMP = 9.
- Reset:
  - On the edge where reset is high: State goes to FETCH, the wait counter to 0, the class register to NONE.
  - While reset is asserted, every strobe is forced to 0: IMReq, IRWE, PCWE, RegWE, DMReq, DMWE, InstrDone, Illegal and Timeout.
  - All selects are 0 during reset.
  - Reset mid-instruction aborts it with no GPR, DM or PC write.
- Supported encodings:
  - Opcode 000000 with Funct 100001 (addu), 100011 (subu), 001000 (jr), 000000 (nop).
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- Class latching: the instruction class is latched on leaving DECODE. All later states use the latched class and ignore Opcode/Funct.
- Output timing: outputs are combinational from state and class, plus Zero, IMReady and DMReady where noted. Strobes not listed in a state are 0.
- FETCH:
  - IMReq = 1.
  - If IMReady: IRWE = 1, PCWE = 1, PCSel = 0, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE, next state by instruction:
  - addu or subu goes to EXEC_R.
  - ori or lui goes to EXEC_I.
  - lw or sw goes to MADDR.
  - beq goes to BRANCH.
  - j, jal or jr goes to JUMP.
  - nop: InstrDone = 1, next state FETCH.
  - Anything else: Illegal = 1, next state FETCH.
- EXEC_R: ALUBSel = 0, ALUCtrl = ADD for addu or SUB for subu. Next state WB.
- EXEC_I:
  - ALUBSel = 1, ALUCtrl = OR.
  - EXTCtrl = 0 for ori, 2 for lui.
  - Next state WB.
- MADDR: ALUBSel = 1, EXTCtrl = 1, ALUCtrl = ADD. Next state MRD for lw, MWR for sw.
- MRD:
  - DMReq = 1.
  - If DMReady, next state WB.
- MWR:
  - DMReq = 1, DMWE = 1.
  - If DMReady: InstrDone = 1, next state FETCH.
- WB:
  - RegWE = 1, InstrDone = 1, next state FETCH.
  - addu/subu: RegA3Sel = 1, DatatoReg = 0.
  - ori: RegA3Sel = 0, DatatoReg = 0.
  - lui: RegA3Sel = 0, DatatoReg = 3, EXTCtrl = 2 held.
  - lw: RegA3Sel = 0, DatatoReg = 1.
- BRANCH:
  - ALUBSel = 0, ALUCtrl = SUB, PCSel = 1.
  - PCWE = Zero.
  - InstrDone = 1, next state FETCH.
- JUMP:
  - PCWE = 1, InstrDone = 1, next state FETCH.
  - PCSel = 2 for j/jal, 3 for jr.
  - jal additionally: RegWE = 1, RegA3Sel = 2, DatatoReg = 2 (PC already advanced, so this is PC+4).
- Wait counter (8 bits):
  - Increments on each cycle spent in FETCH, MRD or MWR while the corresponding ready is low.
  - Clears on every state change.
  - When count == WAIT_LIMIT-1 and ready is still low: Timeout = 1, next state FETCH, no write strobe that cycle.
  - A timed-out FETCH is retried from the same PC.
  - A ready arriving on the limit cycle wins over the timeout.
- Cycle counts with zero memory latency:
  - addu, subu, ori, lui: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, j, jal, jr: 3 cycles.
  - nop: 2 cycles.
  - Each cycle of ready delay adds one cycle.

Test Plan:
- Reset, then ori (Opcode = 001101) with IMReady held high:
  - Required State sequence 0, 1, 3, 7, 0.
  - WB cycle: RegWE = 1, EXTCtrl = 0, RegA3Sel = 0.
  - InstrDone pulses on cycle 4 only.
- lw with DMReady low for 3 cycles in MRD:
  - State sequence 0, 1, 4, 5, 5, 5, 5, 7, 0.
  - DMReq = 1 for all four MRD cycles; DMWE = 0 throughout.
  - WB cycle: DatatoReg = 1.
- beq twice:
  - Zero = 1: BRANCH cycle PCWE = 1, PCSel = 1.
  - Zero = 0: PCWE = 0.
  - Both cases: InstrDone = 1.
- jal, then jr (Opcode = 0, Funct = 001000):
  - jal JUMP cycle: PCSel = 2, RegWE = 1, RegA3Sel = 2, DatatoReg = 2.
  - jr JUMP cycle: PCSel = 3, RegWE = 0.
- Opcode 111111 -> Illegal pulses in DECODE, next state FETCH, no RegWE, DMWE or PCWE.
- Timeout and mid-instruction reset, with WAIT_LIMIT = 4:
  - Hold IMReady low -> Timeout pulses on the 4th FETCH cycle and the FSM stays in FETCH.
  - Assert reset while in MWR -> DMWE = 0 that cycle, State = 0 afterward.
